// File: rtl/arbitro_rr_8entradas.sv
// arbitro_rr_8entradas: round-robin arbiter for eight requesters sharing a
// 5-bit operand path. A grant is held while the grantee keeps its request
// high. Every release passes through one LIBERA cycle and then one OCIOSO
// cycle before the next grant.
// Optional build macro ARBITRO_TIMEOUT_EN: when defined, a grant that has
// lasted MAX_CICLOS cycles is revoked, and expirou pulses for one cycle.
// When the macro is undefined, expirou is tied to 0.
//
// state     | meaning
// ----------+------------------------------------------------------------
// OCIOSO    | no grant; arbitrate among req starting from ptr
// CONCEDIDO | grant held on key/concessao while req[key] stays high
// LIBERA    | one dead cycle after a release or revocation; ptr updated
module arbitro_rr_8entradas #(
    parameter int MAX_CICLOS = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  req,
    input  logic [39:0] entradas,
    output logic [2:0]  key,
    output logic [7:0]  concessao,
    output logic        valido,
    output logic        expirou,
    output logic [4:0]  saida
);

    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        CONCEDIDO = 2'd1,
        LIBERA    = 2'd2
    } estado_t;

    // Stops elaboration when the timeout length is outside 2..255.
    if (MAX_CICLOS < 2 || MAX_CICLOS > 255) begin : g_max_ciclos_invalido
        $error("MAX_CICLOS out of range 2..255");
    end

    estado_t    estado_q, estado_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] key_q, key_d;
    logic [7:0] concessao_q, concessao_d;
    logic       valido_q, valido_d;

`ifdef ARBITRO_TIMEOUT_EN
    localparam logic [7:0] LIMITE = 8'(MAX_CICLOS - 1);
    logic [7:0] cnt_q, cnt_d;
    logic       expirou_q, expirou_d;
`endif

    logic       hay_req;
    logic [2:0] sel_idx;
    logic [2:0] scan_idx;

    // Finds the first active requester, scanning from ptr upward with wrap.
    always_comb begin
        hay_req  = 1'b0;
        sel_idx  = 3'd0;
        scan_idx = 3'd0;
        for (int k = 0; k < 8; k++) begin
            scan_idx = ptr_q + 3'(k);
            if (!hay_req && req[scan_idx]) begin
                hay_req = 1'b1;
                sel_idx = scan_idx;
            end
        end
    end

    // Computes the next state and the next registered outputs.
    always_comb begin
        estado_d    = estado_q;
        ptr_d       = ptr_q;
        key_d       = key_q;
        concessao_d = concessao_q;
        valido_d    = valido_q;
`ifdef ARBITRO_TIMEOUT_EN
        cnt_d       = cnt_q;
        expirou_d   = 1'b0;
`endif
        case (estado_q)
            OCIOSO: begin
                if (hay_req) begin
                    estado_d    = CONCEDIDO;
                    key_d       = sel_idx;
                    concessao_d = 8'd1 << sel_idx;
                    valido_d    = 1'b1;
`ifdef ARBITRO_TIMEOUT_EN
                    cnt_d       = 8'd0;
`endif
                end
            end
            CONCEDIDO: begin
                // A voluntary release wins over a timeout on the same edge.
                if (!req[key_q]) begin
                    estado_d    = LIBERA;
                    concessao_d = 8'd0;
                    valido_d    = 1'b0;
                    ptr_d       = key_q + 3'd1;
                end
`ifdef ARBITRO_TIMEOUT_EN
                else if (cnt_q == LIMITE) begin
                    estado_d    = LIBERA;
                    concessao_d = 8'd0;
                    valido_d    = 1'b0;
                    ptr_d       = key_q + 3'd1;
                    expirou_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            LIBERA: begin
                estado_d = OCIOSO;
            end
            default: begin
                estado_d    = OCIOSO;
                concessao_d = 8'd0;
                valido_d    = 1'b0;
            end
        endcase
    end

    // Registers the state and outputs; reset overrides everything.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q    <= OCIOSO;
            ptr_q       <= 3'd0;
            key_q       <= 3'd0;
            concessao_q <= 8'd0;
            valido_q    <= 1'b0;
`ifdef ARBITRO_TIMEOUT_EN
            cnt_q       <= 8'd0;
            expirou_q   <= 1'b0;
`endif
        end else begin
            estado_q    <= estado_d;
            ptr_q       <= ptr_d;
            key_q       <= key_d;
            concessao_q <= concessao_d;
            valido_q    <= valido_d;
`ifdef ARBITRO_TIMEOUT_EN
            cnt_q       <= cnt_d;
            expirou_q   <= expirou_d;
`endif
        end
    end

    assign key       = key_q;
    assign concessao = concessao_q;
    assign valido    = valido_q;
`ifdef ARBITRO_TIMEOUT_EN
    assign expirou   = expirou_q;
`else
    assign expirou   = 1'b0;
`endif

    // Shared operand mux: the grantee's slice, or zero when there is no grant.
    always_comb begin
        saida = 5'd0;
        if (valido_q) begin
            saida = entradas[int'(key_q) * 5 +: 5];
        end
    end

endmodule
